input_buffer: RTL and testbench
===============================

INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 SHALL provide parameter FLIT_W, default 16, flit width in bits.
REQ-002 SHALL provide parameter DEPTH, default 4, flit capacity; legal values are powers of two from 2 to 16.
REQ-003 SHALL define CNT_W = log2(DEPTH)+1 as a localparam.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-006 SHALL have port ib_data_i  input  FLIT_W  flit from the upstream router or local port.
REQ-007 SHALL have port ib_write_i  input  1  push request, qualifying ib_data_i.
REQ-008 SHALL have port ib_read_i  input  1  pop request from the arbiter read output.
REQ-009 SHALL have port ib_data_o  output  FLIT_W  head flit, driven to the crossbar.
REQ-010 SHALL have port ib_addr_header_o  output  FLIT_W  head flit, driven to the arbiter address input; bits [7:0] carry the YX destination.
REQ-011 SHALL have port ib_empty_o  output  1  buffer holds 0 flits.
REQ-012 SHALL have port ib_full_o  output  1  buffer holds DEPTH flits.
REQ-013 SHALL have port ib_count_o  output  CNT_W  current occupancy.
REQ-014 SHALL have port ib_credit_o  output  1  one-cycle credit-return pulse to the upstream sender.
REQ-015 SHALL have port ib_overflow_o  output  1  sticky error flag set by a dropped write.

Function
REQ-016 SHALL implement a circular FIFO with a write pointer, a read pointer (each log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and an occupancy counter of CNT_W bits.
REQ-017 SHALL accept a write when ib_write_i=1 and either count<DEPTH, or count=DEPTH with an accepted read in the same cycle.
REQ-018 SHALL accept a read when ib_read_i=1 and count>0; a read at count=0 is ignored, with no pointer change and no credit.
REQ-019 SHALL, when a write arrives at count=0 together with a read, accept the write and ignore the read (no fall-through path).
REQ-020 SHALL, on simultaneous accepted read and write, advance both pointers and hold count unchanged.
REQ-021 SHALL, on a write at count=DEPTH without an accepted read, drop the flit, leave the FIFO contents unchanged, and set ib_overflow_o to 1 until reset.
REQ-022 SHALL drive ib_data_o and ib_addr_header_o combinationally from the storage entry at the read pointer; both SHALL equal the same value at all times.
REQ-023 SHALL make a written flit visible at the head one cycle after the write edge; write-to-head latency is 1 cycle when the FIFO was empty.
REQ-024 SHALL derive ib_empty_o = (count==0), ib_full_o = (count==DEPTH) and ib_count_o = count from registered state only.
REQ-025 SHALL register ib_credit_o and assert it for exactly one cycle in the cycle following each accepted read; back-to-back reads SHALL produce back-to-back pulses.
REQ-026 SHALL keep the storage array without reset; head outputs while empty are don't-care and SHALL NOT be checked.
REQ-027 SHALL NOT interpret flit contents; packet boundaries are tracked downstream by the arbiter.

Reset
REQ-028 SHALL, while reset=0, asynchronously force both pointers=0, count=0, ib_empty_o=1, ib_full_o=0, ib_count_o=0, ib_credit_o=0 and ib_overflow_o=0.
REQ-029 SHALL, on reset asserted mid-operation, discard all stored flits and suppress any pending credit pulse.
REQ-030 SHALL ignore ib_write_i and ib_read_i while reset=0 and in the first edge after deassertion only if they were sampled during reset; the first post-reset edge with reset=1 SHALL operate normally.

Verification
REQ-031 Push test: DEPTH=4, write 16'h0011, 16'h0022, 16'h0033, 16'h0044 on consecutive cycles -> ib_count_o 1,2,3,4; ib_full_o=1 after the 4th edge; ib_addr_header_o=16'h0011 from the edge after the 1st write onward.
REQ-032 Drain test: from full, assert ib_read_i for 4 cycles -> head shows 0022, 0033, 0044 in turn; ib_credit_o high for 4 consecutive cycles, each lagging its read by one cycle; ib_empty_o=1 after the 4th read.
REQ-033 Overflow test: when full, write 16'h0055 with no read -> flit dropped, count stays 4, ib_overflow_o=1 and remains set; the following reads return 0011..0044 only.
REQ-034 Simultaneous-operation test: full with read+write of 16'h0066 -> count stays 4, no overflow; empty with read+write of 16'h0077 -> count becomes 1, no credit, head=0077.
REQ-035 Wrap test: run 10 interleaved write/read pairs through a DEPTH=4 FIFO -> data order is preserved across pointer wrap, and credits total 10.
REQ-036 Reset test: reset=0 asserted asynchronously mid-stream with count=3 and a credit pulse pending -> all outputs return immediately to their reset values, with no credit pulse after release.

Source files
------------

// File: rtl/input_buffer.sv
// Router input buffer: a circular FIFO of flits with occupancy status, a registered
// credit-return pulse per popped flit and a sticky overflow flag for dropped writes.
// The head entry feeds both the crossbar and the arbiter address input.
module input_buffer #(
   parameter int unsigned FLIT_W = 16,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] ib_data_i,
   input  logic              ib_write_i,
   input  logic              ib_read_i,
   output logic [FLIT_W-1:0] ib_data_o,
   output logic [FLIT_W-1:0] ib_addr_header_o,
   output logic              ib_empty_o,
   output logic              ib_full_o,
   output logic [CNT_W-1:0]  ib_count_o,
   output logic              ib_credit_o,
   output logic              ib_overflow_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              credit_q;
   logic              overflow_q;

   logic is_empty, is_full;
   logic rd_accept, wr_accept, wr_drop;

   // Accept decisions; a read on an empty buffer never lets a same-cycle write fall through.
   always_comb begin
      is_empty  = (count_q == '0);
      is_full   = (count_q == FULL_CNT);
      rd_accept = ib_read_i && !is_empty;
      wr_accept = ib_write_i && (!is_full || rd_accept);
      wr_drop   = ib_write_i && !wr_accept;
   end

   // Flit storage, deliberately without reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= ib_data_i;
      end
   end

   // Pointers, occupancy, credit pulse and sticky overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         credit_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_accept) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         unique case ({wr_accept, rd_accept})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         credit_q <= rd_accept;
         if (wr_drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign ib_data_o        = mem[rd_ptr_q];
   assign ib_addr_header_o = mem[rd_ptr_q];
   assign ib_empty_o       = is_empty;
   assign ib_full_o        = is_full;
   assign ib_count_o       = count_q;
   assign ib_credit_o      = credit_q;
   assign ib_overflow_o    = overflow_q;

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer with a flit scoreboard queue: written flits are
// pushed when driven and popped/compared at the head when a read is accepted.
module tb_input_buffer;

   localparam int unsigned FLIT_W = 16;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [FLIT_W-1:0] ib_data_i;
   logic              ib_write_i;
   logic              ib_read_i;
   logic [FLIT_W-1:0] ib_data_o;
   logic [FLIT_W-1:0] ib_addr_header_o;
   logic              ib_empty_o;
   logic              ib_full_o;
   logic [CNT_W-1:0]  ib_count_o;
   logic              ib_credit_o;
   logic              ib_overflow_o;

   input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset            (reset),
      .ib_data_i        (ib_data_i),
      .ib_write_i       (ib_write_i),
      .ib_read_i        (ib_read_i),
      .ib_data_o        (ib_data_o),
      .ib_addr_header_o (ib_addr_header_o),
      .ib_empty_o       (ib_empty_o),
      .ib_full_o        (ib_full_o),
      .ib_count_o       (ib_count_o),
      .ib_credit_o      (ib_credit_o),
      .ib_overflow_o    (ib_overflow_o)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          credit_seen = 0;
   logic [15:0] sb[$];
   logic        exp_ovf = 1'b0;
   logic        exp_credit = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"},    32'(ib_count_o),    32'(sb.size()));
      check({tag, ".empty"},    32'(ib_empty_o),    32'(sb.size() == 0));
      check({tag, ".full"},     32'(ib_full_o),     32'(sb.size() == int'(DEPTH)));
      check({tag, ".credit"},   32'(ib_credit_o),   32'(exp_credit));
      check({tag, ".overflow"}, 32'(ib_overflow_o), 32'(exp_ovf));
      if (sb.size() > 0) begin
         check({tag, ".head"}, 32'(ib_data_o), 32'(sb[0]));
         check({tag, ".hdr"},  32'(ib_addr_header_o), 32'(sb[0]));
      end
   endtask

   // One clock of stimulus; the model decides acceptance from its own occupancy.
   task automatic step(input string tag, input logic w, input logic [15:0] d, input logic r);
      logic rd_acc, wr_acc;
      rd_acc = r && (sb.size() > 0);
      wr_acc = w && ((sb.size() < int'(DEPTH)) || rd_acc);
      if (rd_acc) check({tag, ".pop"}, 32'(ib_data_o), 32'(sb[0]));
      ib_write_i = w;
      ib_data_i  = d;
      ib_read_i  = r;
      @(posedge clk);
      #1;
      ib_write_i = 1'b0;
      ib_read_i  = 1'b0;
      if (rd_acc) void'(sb.pop_front());
      if (wr_acc) sb.push_back(d);
      if (w && !wr_acc) exp_ovf = 1'b1;
      exp_credit = rd_acc;
      if (ib_credit_o) credit_seen++;
      check_state(tag);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      sb.delete();
      exp_ovf    = 1'b0;
      exp_credit = 1'b0;
      check_state("rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      ib_data_i  = '0;
      ib_write_i = 1'b0;
      ib_read_i  = 1'b0;
      do_reset();

      // Push: 0011..0044, head stays 0011, full after the 4th write.
      step("push1", 1'b1, 16'h0011, 1'b0);
      step("push2", 1'b1, 16'h0022, 1'b0);
      step("push3", 1'b1, 16'h0033, 1'b0);
      step("push4", 1'b1, 16'h0044, 1'b0);
      check("push.hdr_lit", 32'(ib_addr_header_o), 32'h0011);

      // Drain: four back-to-back reads, credits back-to-back.
      credit_seen = 0;
      for (int i = 0; i < 4; i++) step("drain", 1'b0, 16'h0, 1'b1);
      check("drain.credits", 32'(credit_seen), 32'd4);
      step("drain_idle", 1'b0, 16'h0, 1'b0);
      step("read_empty", 1'b0, 16'h0, 1'b1);

      // Simultaneous read+write when full, then when empty.
      step("fill1", 1'b1, 16'h0101, 1'b0);
      step("fill2", 1'b1, 16'h0202, 1'b0);
      step("fill3", 1'b1, 16'h0303, 1'b0);
      step("fill4", 1'b1, 16'h0404, 1'b0);
      step("rw_full", 1'b1, 16'h0066, 1'b1);
      for (int i = 0; i < 4; i++) step("rw_drain", 1'b0, 16'h0, 1'b1);
      step("rw_empty", 1'b1, 16'h0077, 1'b1);
      check("rw_empty.head_lit", 32'(ib_data_o), 32'h0077);
      check("rw_empty.no_credit", 32'(ib_credit_o), 32'd0);
      step("rw_pop77", 1'b0, 16'h0, 1'b1);
      step("rw_idle", 1'b0, 16'h0, 1'b0);

      // Wrap: 10 write/read pairs.
      credit_seen = 0;
      for (int i = 0; i < 10; i++) begin
         step("wrap_w", 1'b1, 16'h1000 + 16'(i), 1'b0);
         step("wrap_r", 1'b0, 16'h0, 1'b1);
      end
      step("wrap_idle", 1'b0, 16'h0, 1'b0);
      check("wrap.credits", 32'(credit_seen), 32'd10);

      // Overflow: write when full is dropped, flag sticks.
      step("of1", 1'b1, 16'h0011, 1'b0);
      step("of2", 1'b1, 16'h0022, 1'b0);
      step("of3", 1'b1, 16'h0033, 1'b0);
      step("of4", 1'b1, 16'h0044, 1'b0);
      step("of_drop", 1'b1, 16'h0055, 1'b0);
      check("of.flag_lit", 32'(ib_overflow_o), 32'd1);
      step("of_hold", 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 4; i++) step("of_drain", 1'b0, 16'h0, 1'b1);
      step("of_idle", 1'b0, 16'h0, 1'b0);

      // Reset mid-stream with count=3 and a credit pulse showing.
      step("rs1", 1'b1, 16'h00a1, 1'b0);
      step("rs2", 1'b1, 16'h00a2, 1'b0);
      step("rs3", 1'b1, 16'h00a3, 1'b0);
      step("rs4", 1'b1, 16'h00a4, 1'b0);
      step("rs_rd", 1'b0, 16'h0, 1'b1);
      check("rs.pending_credit", 32'(ib_credit_o), 32'd1);
      reset = 1'b0;
      ib_write_i = 1'b1;
      ib_read_i  = 1'b1;
      ib_data_i  = 16'hdead;
      #1;
      sb.delete();
      exp_ovf    = 1'b0;
      exp_credit = 1'b0;
      check_state("rs_async");
      repeat (2) @(posedge clk);
      #1;
      check_state("rs_held");
      @(negedge clk);
      ib_write_i = 1'b0;
      ib_read_i  = 1'b0;
      reset = 1'b1;
      step("rs_post", 1'b0, 16'h0, 1'b0);
      step("rs_wr", 1'b1, 16'h00aa, 1'b0);
      step("rs_rd2", 1'b0, 16'h0, 1'b1);
      step("rs_end", 1'b0, 16'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
